usb2_ep1_in: RTL and testbench

USB2_EP1_IN -- requirements
Module: usb2_ep1_in

---
 rtl/usb2_ep1_in.sv | 189 ++++++++++++++++++
 tb/tb_usb2_ep1_in.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb2_ep1_in.sv
// usb2_ep1_in -- bulk IN endpoint 1 packet buffer for a USB2 device core.
// The application fills a bank byte by byte and commits it; the protocol
// engine drains the committed bank and releases it only on an ACK handshake,
// so any other handshake makes the retry resend the identical packet.
// Build option: define USB2_EP1_DOUBLE_BUF_EN for two ping-pong 512x8 banks;
// left undefined, a single 512x8 bank is used and both bank indices are 0.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for a rising edge on xfer_out
// ST_XFER | IN transaction in flight; drain bank, length and PID frozen
// ST_DONE | handshake PID latched; release the bank on ACK, then idle
module usb2_ep1_in (
  input  logic       phy_clk,
  input  logic       reset,
  input  logic [7:0] app_wr_data,
  input  logic       app_wr_en,
  input  logic       app_commit,
  output logic       app_ready,
  input  logic       xfer_out,
  input  logic [3:0] xfer_pid,
  output logic       xfer_ready,
  input  logic [8:0] buf_out_addr,
  output logic [7:0] buf_out_q,
  output logic [9:0] buf_out_len,
  output logic [3:0] data_pid,
  input  logic       clear_toggle,
  output logic       err_overflow
);

  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [9:0] MAX_LEN   = 10'd512;

`ifdef USB2_EP1_DOUBLE_BUF_EN
  localparam int NBANK  = 2;
  localparam int MEM_AW = 10;
`else
  localparam int NBANK  = 1;
  localparam int MEM_AW = 9;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_xfer_out_1;
  logic [3:0]  r_pid;
  logic        w_release;

  logic [7:0]  r_mem [NBANK*512];
  logic [7:0]  r_q;
  logic [1:0]  r_full;
  logic [9:0]  r_len [2];
  logic [9:0]  r_count;
  logic        r_toggle;
  logic        r_err_overflow;

  logic              w_fill_sel;
  logic              w_drain_sel;
  logic [MEM_AW-1:0] w_wr_addr;
  logic [MEM_AW-1:0] w_rd_addr;
  logic              w_commit;
  logic              w_wr;
  logic              w_overflow;

`ifdef USB2_EP1_DOUBLE_BUF_EN
  logic r_fill_sel;
  logic r_drain_sel;

  // ping-pong bank indices: fill advances on commit, drain on ACK release
  always_ff @(posedge phy_clk) begin
    if (reset) begin
      r_fill_sel  <= 1'b0;
      r_drain_sel <= 1'b0;
    end else begin
      if (w_commit)
        r_fill_sel <= ~r_fill_sel;
      if (w_release)
        r_drain_sel <= ~r_drain_sel;
    end
  end

  assign w_fill_sel  = r_fill_sel;
  assign w_drain_sel = r_drain_sel;
  assign w_wr_addr   = {w_fill_sel, r_count[8:0]};
  assign w_rd_addr   = {w_drain_sel, buf_out_addr};
`else
  assign w_fill_sel  = 1'b0;
  assign w_drain_sel = 1'b0;
  assign w_wr_addr   = r_count[8:0];
  assign w_rd_addr   = buf_out_addr;
`endif

  assign app_ready    = ~r_full[w_fill_sel];
  assign xfer_ready   = r_full[w_drain_sel];
  assign buf_out_len  = r_len[w_drain_sel];
  assign buf_out_q    = r_q;
  assign data_pid     = r_toggle ? PID_DATA1 : PID_DATA0;
  assign err_overflow = r_err_overflow;

  // a commit takes priority over a write in the same cycle; that byte is dropped
  assign w_commit   = app_commit & app_ready;
  assign w_wr       = app_wr_en & app_ready & (r_count != MAX_LEN) & ~app_commit;
  assign w_overflow = (app_wr_en & (~app_ready | (r_count == MAX_LEN)))
                    | (app_commit & ~app_ready);

  // fill side: byte counter, bank-full flags, committed lengths, sticky overflow
  always_ff @(posedge phy_clk) begin
    if (reset) begin
      r_count        <= '0;
      r_full         <= 2'b00;
      r_len[0]       <= '0;
      r_len[1]       <= '0;
      r_err_overflow <= 1'b0;
    end else begin
      if (w_commit) begin
        r_count           <= '0;
        r_len[w_fill_sel] <= r_count;
      end else if (w_wr) begin
        r_count <= r_count + 10'd1;
      end
      if (w_release)
        r_full[w_drain_sel] <= 1'b0;
      if (w_commit)
        r_full[w_fill_sel] <= 1'b1;
      if (w_overflow)
        r_err_overflow <= 1'b1;
    end
  end

  // packet storage; contents deliberately survive reset
  always_ff @(posedge phy_clk) begin
    if (w_wr)
      r_mem[w_wr_addr] <= app_wr_data;
  end

  // registered drain-bank read port
  always_ff @(posedge phy_clk) begin
    if (reset)
      r_q <= 8'h00;
    else
      r_q <= r_mem[w_rd_addr];
  end

  // data toggle: clear_toggle overrides a coincident ACK toggle
  always_ff @(posedge phy_clk) begin
    if (reset)
      r_toggle <= 1'b0;
    else if (clear_toggle)
      r_toggle <= 1'b0;
    else if (w_release)
      r_toggle <= ~r_toggle;
  end

  // drain FSM state register, xfer_out edge history and handshake latch
  always_ff @(posedge phy_clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_xfer_out_1 <= 1'b0;
      r_pid        <= 4'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_xfer_out_1 <= xfer_out;
      if (r_state == ST_XFER && !xfer_out)
        r_pid <= xfer_pid;
    end
  end

  // drain FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (xfer_out && !r_xfer_out_1) w_state_nxt = ST_XFER;
      ST_XFER: if (!xfer_out)                 w_state_nxt = ST_DONE;
      ST_DONE:                                w_state_nxt = ST_IDLE;
      default:                                w_state_nxt = ST_IDLE;
    endcase
  end

  // drain FSM output: release the drain bank only on an ACK for a held packet
  always_comb begin
    w_release = 1'b0;
    if (r_state == ST_DONE && r_pid == PID_ACK && r_full[w_drain_sel])
      w_release = 1'b1;
  end

endmodule

// File: tb/tb_usb2_ep1_in.sv
// tb_usb2_ep1_in -- bench for usb2_ep1_in. The reference model treats the
// endpoint as a FIFO of committed packets with capacity NB (1 or 2 banks,
// following USB2_EP1_DOUBLE_BUF_EN), plus a fill buffer and a data toggle.
module tb_usb2_ep1_in;

`ifdef USB2_EP1_DOUBLE_BUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic       phy_clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] app_wr_data = '0;
  logic       app_wr_en = 1'b0;
  logic       app_commit = 1'b0;
  logic       app_ready;
  logic       xfer_out = 1'b0;
  logic [3:0] xfer_pid = '0;
  logic       xfer_ready;
  logic [8:0] buf_out_addr = '0;
  logic [7:0] buf_out_q;
  logic [9:0] buf_out_len;
  logic [3:0] data_pid;
  logic       clear_toggle = 1'b0;
  logic       err_overflow;

  usb2_ep1_in dut (
    .phy_clk      (phy_clk),
    .reset        (reset),
    .app_wr_data  (app_wr_data),
    .app_wr_en    (app_wr_en),
    .app_commit   (app_commit),
    .app_ready    (app_ready),
    .xfer_out     (xfer_out),
    .xfer_pid     (xfer_pid),
    .xfer_ready   (xfer_ready),
    .buf_out_addr (buf_out_addr),
    .buf_out_q    (buf_out_q),
    .buf_out_len  (buf_out_len),
    .data_pid     (data_pid),
    .clear_toggle (clear_toggle),
    .err_overflow (err_overflow)
  );

  always #5 phy_clk = ~phy_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_fill [512];
  logic [7:0] m_data [2][512];
  int         m_len  [2];
  int         m_head, m_cnt, m_fcnt;
  bit         m_tog, m_err;

  task automatic tick();
    @(posedge phy_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_head = 0; m_cnt = 0; m_fcnt = 0; m_tog = 1'b0; m_err = 1'b0;
  endfunction

  function automatic void m_write(input logic [7:0] b);
    if (m_cnt < NB && m_fcnt < 512) begin
      m_fill[m_fcnt] = b;
      m_fcnt++;
    end else begin
      m_err = 1'b1;
    end
  endfunction

  function automatic void m_commit();
    int slot;
    if (m_cnt < NB) begin
      slot = (m_head + m_cnt) % NB;
      for (int i = 0; i < m_fcnt; i++) m_data[slot][i] = m_fill[i];
      m_len[slot] = m_fcnt;
      m_cnt++;
      m_fcnt = 0;
    end else begin
      m_err = 1'b1;
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "/app_ready"}, app_ready, (m_cnt < NB) ? 1 : 0);
    chk({tag, "/xfer_ready"}, xfer_ready, (m_cnt > 0) ? 1 : 0);
    chk({tag, "/data_pid"}, data_pid, m_tog ? 4'hB : 4'h3);
    chk({tag, "/err_overflow"}, err_overflow, m_err);
    if (m_cnt > 0) chk({tag, "/len"}, buf_out_len, m_len[m_head]);
  endtask

  task automatic do_reset();
    reset = 1'b1; app_wr_en = 0; app_commit = 0; xfer_out = 0; clear_toggle = 0;
    tick();
    tick();
    reset = 1'b0;
    m_reset();
    chk("rst/q", buf_out_q, 8'h00);
    check_all("rst");
  endtask

  // mode 0: incrementing from base, mode 1: random bytes
  task automatic write_burst(input int n, input int base, input bit rnd);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = rnd ? 8'($urandom) : 8'(base + i);
      app_wr_data = b;
      app_wr_en = 1'b1;
      tick();
      m_write(b);
    end
    app_wr_en = 1'b0;
  endtask

  task automatic commit_pkt();
    app_commit = 1'b1;
    tick();
    app_commit = 1'b0;
    m_commit();
  endtask

  // one IN transaction; clr/cmt are pulsed in the cycle the handshake is acted on
  task automatic xfer(input logic [3:0] pid, input int hold, input bit clr, input bit cmt);
    int old_cnt;
    xfer_out = 1'b1;
    tick();
    repeat (hold) tick();
    xfer_out = 1'b0;
    xfer_pid = pid;
    tick();
    clear_toggle = clr;
    app_commit = cmt;
    tick();
    clear_toggle = 1'b0;
    app_commit = 1'b0;
    xfer_pid = 4'h0;
    old_cnt = m_cnt;
    if (cmt) m_commit();
    if (pid == 4'h2 && old_cnt > 0) begin
      m_head = (m_head + 1) % NB;
      m_cnt--;
      m_tog = ~m_tog;
    end
    if (clr) m_tog = 1'b0;
  endtask

  task automatic read_chk(input int addr);
    buf_out_addr = 9'(addr);
    tick();
    chk("rd/q", buf_out_q, m_data[m_head][addr]);
  endtask

  initial begin
    int op, n;
    logic [3:0] pid;

    m_reset();
    do_reset();

    // 64-byte packet, readback, initial DATA0
    write_burst(64, 0, 0);
    commit_pkt();
    check_all("p64");
    chk("p64/len", buf_out_len, 10'd64);
    buf_out_addr = 9'd5;
    tick();
    chk("p64/q5", buf_out_q, 8'h05);
    read_chk(63);

    // ACK releases and toggles; second packet toggles back
    xfer(4'h2, 0, 0, 0);
    check_all("ack1");
    chk("ack1/pid", data_pid, 4'hB);
    write_burst(10, 0, 1);
    commit_pkt();
    read_chk(9);
    xfer(4'h2, 2, 0, 0);
    check_all("ack2");
    chk("ack2/pid", data_pid, 4'h3);

    // NAK-like handshake keeps the packet, then ACK releases it
    write_burst(20, 8'h40, 0);
    commit_pkt();
    xfer(4'h0, 1, 0, 0);
    check_all("nak");
    chk("nak/ready", xfer_ready, 1'b1);
    chk("nak/len", buf_out_len, 10'd20);
    read_chk(19);
    xfer(4'h2, 0, 0, 0);
    check_all("nak_ack");

    // ACK with nothing committed changes nothing
    xfer(4'h2, 0, 0, 0);
    check_all("ack_empty");

    // write at count 512 overflows
    do_reset();
    write_burst(513, 0, 0);
    check_all("ovf513");
    chk("ovf513/err", err_overflow, 1'b1);

    // full 512-byte packet (plus zero-length in double mode), then a blocked write
    do_reset();
    write_burst(512, 0, 0);
    commit_pkt();
    if (NB == 2) commit_pkt();
    check_all("full");
    chk("full/app_ready", app_ready, 1'b0);
    chk("full/err0", err_overflow, 1'b0);
    chk("full/len512", buf_out_len, 10'd512);
    write_burst(1, 8'hAA, 0);
    check_all("full_wr");
    chk("full_wr/err", err_overflow, 1'b1);
    read_chk(511);
    read_chk(300);
    xfer(4'h2, 0, 0, 0);
    check_all("drain1");
    if (NB == 2) begin
      chk("drain1/len0", buf_out_len, 10'd0);
      xfer(4'h2, 0, 0, 0);
      check_all("drain2");
    end

    // commit coincident with ACK release
    do_reset();
    write_burst(8, 8'h10, 0);
    commit_pkt();
    write_burst(5, 8'h80, 0);
    xfer(4'h2, 0, 0, 1);
    check_all("coinc");
    if (NB == 2) begin
      chk("coinc/xfer_ready", xfer_ready, 1'b1);
      chk("coinc/len", buf_out_len, 10'd5);
      read_chk(4);
      xfer(4'h2, 0, 0, 0);
      check_all("coinc_drain");
    end

    // clear_toggle coincident with ACK: DATA0 wins
    do_reset();
    write_burst(3, 0, 1);
    commit_pkt();
    xfer(4'h2, 0, 0, 0);
    write_burst(4, 0, 1);
    commit_pkt();
    xfer(4'h2, 0, 1, 0);
    check_all("clr_ack");
    chk("clr_ack/pid", data_pid, 4'h3);

    // reset in the middle of a transaction
    write_burst(6, 0, 1);
    commit_pkt();
    xfer(4'h2, 0, 0, 0);
    write_burst(7, 0, 1);
    commit_pkt();
    xfer_out = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    xfer_out = 1'b0;
    tick();
    chk("rst_xfer/xfer_ready", xfer_ready, 1'b0);
    chk("rst_xfer/app_ready", app_ready, 1'b1);
    chk("rst_xfer/pid", data_pid, 4'h3);
    reset = 1'b0;
    m_reset();
    check_all("rst_xfer");

    // randomized traffic against the model
    for (int it = 0; it < 80; it++) begin
      op = int'($urandom_range(0, 5));
      case (op)
        0: begin
          n = int'($urandom_range(0, 40));
          write_burst(n, 0, 1);
        end
        1: commit_pkt();
        2: begin
          n = int'($urandom_range(0, 3));
          pid = 4'($urandom_range(0, 3));
          if (pid == 4'h3) pid = 4'hA;
          xfer(pid, n, 0, 0);
        end
        3: begin
          if (m_cnt > 0 && m_len[m_head] > 0) begin
            for (int k = 0; k < 3; k++)
              read_chk(int'($urandom_range(0, m_len[m_head] - 1)));
          end
        end
        4: begin
          clear_toggle = 1'b1;
          tick();
          clear_toggle = 1'b0;
          m_tog = 1'b0;
        end
        default: xfer(4'h2, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      endcase
      check_all("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
